cmp_config_param: RTL and testbench

Parametrised CMP_CONFIG packet parser for crypt-format cores. Sits between the packet-communication input FIFO and the per-core comparator and salt/iteration storage. Salt length, iteration-count width, comparator bytes per hash and hash capacity are generic. It adds the following checks: range checks with error codes, a rounds=0 check, zero-padding of salt beyond `salt_len`, a hash-count capacity check, and a done pulse.

---
 rtl/cmp_config_pkg.sv | 43 ++++
 rtl/cmp_config_ram.sv | 26 ++
 rtl/cmp_config_param.sv | 279 +++++++++++++++++++++++++++
 tb/tb_cmp_config_param.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_config_pkg.sv
// Shared definitions for the CMP_CONFIG packet parser: FSM encoding, error codes,
// config RAM layout and derived-width helpers.
package cmp_config_pkg;

    typedef enum logic [3:0] {
        StNone,
        StWaitApplied,
        StSaltLen,
        StSalt,
        StIter,
        StHc0,
        StHc1,
        StCmpData,
        StMagic,
        StError
    } state_e;

    localparam logic [2:0] ErrNone          = 3'd0;
    localparam logic [2:0] ErrBadStart      = 3'd1;
    localparam logic [2:0] ErrSaltLen       = 3'd2;
    localparam logic [2:0] ErrZeroIter      = 3'd3;
    localparam logic [2:0] ErrHashCount     = 3'd4;
    localparam logic [2:0] ErrUnexpectedCmp = 3'd5;
    localparam logic [2:0] ErrBadMagic      = 3'd6;

    localparam int unsigned IterBase    = 0;
    localparam int unsigned SaltLenAddr = 4;
    localparam int unsigned SaltBase    = 8;

    function automatic int unsigned calc_hc_w(input int unsigned num_hashes);
        return $clog2(num_hashes + 1);
    endfunction

    function automatic int unsigned calc_ca_w(input int unsigned num_hashes,
                                              input int unsigned cmp_bytes);
        return $clog2(num_hashes * cmp_bytes);
    endfunction

    function automatic int unsigned calc_aw(input int unsigned salt_max);
        return $clog2(SaltBase + salt_max);
    endfunction

endpackage

// File: rtl/cmp_config_ram.sv
// Small distributed RAM holding iteration count, salt length and salt:
// one synchronous write port, one asynchronous read port.
module cmp_config_ram #(
    parameter int unsigned AW = 5
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    localparam int unsigned Depth = 1 << AW;

    logic [7:0] mem [Depth];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmp_config_param.sv
// CMP_CONFIG packet parser: validates the packet, stores salt/iteration count in the
// config RAM and streams comparator bytes out to the comparator storage.
module cmp_config_param
    import cmp_config_pkg::*;
#(
    parameter int unsigned SALT_MAX   = 16,
    parameter int unsigned SALT_MIN   = 1,
    parameter int unsigned ITER_BYTES = 4,
    parameter int unsigned CMP_BYTES  = 4,
    parameter int unsigned NUM_HASHES = 512,
    // Derived widths; leave at their defaults.
    parameter int unsigned HC_W       = calc_hc_w(NUM_HASHES),
    parameter int unsigned CA_W       = calc_ca_w(NUM_HASHES, CMP_BYTES),
    parameter int unsigned AW         = calc_aw(SALT_MAX)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    mode_cmp,
    input  logic [7:0]              din,
    input  logic                    wr_en,
    output logic                    full,
    output logic                    error,
    output logic [2:0]              err_code,
    output logic                    new_cmp_config,
    input  logic                    cmp_config_applied,
    output logic                    done,
    output logic [HC_W-1:0]         hash_count,
    output logic [CA_W-1:0]         cmp_wr_addr,
    output logic                    cmp_wr_en,
    output logic [7:0]              cmp_din,
    output logic [8*ITER_BYTES-1:0] iter_count,
    input  logic [AW-1:0]           addr,
    output logic [7:0]              dout
);

    localparam int unsigned IW        = 8 * ITER_BYTES;
    localparam int unsigned CMP_SHIFT = $clog2(CMP_BYTES);

    state_e            state_q, state_d;
    logic              full_q, full_d;
    logic              error_q, error_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              new_q, new_d;
    logic              done_q, done_d;
    logic              cmp_wr_en_q, cmp_wr_en_d;
    logic [CA_W-1:0]   cmp_wr_addr_q, cmp_wr_addr_d;
    logic [7:0]        cmp_din_q, cmp_din_d;
    logic [HC_W-1:0]   hash_count_q, hash_count_d;
    logic [IW-1:0]     iter_count_q, iter_count_d;
    logic [7:0]        salt_len_q, salt_len_d;
    logic [7:0]        hc_lo_q, hc_lo_d;
    logic [7:0]        idx_q, idx_d;

    logic              raise_err;
    logic [2:0]        new_code;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              rd_valid;
    logic [IW-1:0]     iter_shift;
    logic [15:0]       hc_full;
    logic [CA_W-1:0]   cmp_last;

    // Little-endian: each new byte enters at the top and the older ones move down.
    assign iter_shift = IW'({din, iter_count_q} >> 8);
    assign hc_full    = {din, hc_lo_q};
    assign cmp_last   = CA_W'((32'(hash_count_q) << CMP_SHIFT) - 32'd1);

    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        new_d         = new_q;
        done_d        = 1'b0;
        cmp_wr_en_d   = 1'b0;
        cmp_wr_addr_d = cmp_wr_addr_q;
        cmp_din_d     = cmp_din_q;
        hash_count_d  = hash_count_q;
        iter_count_d  = iter_count_q;
        salt_len_d    = salt_len_q;
        hc_lo_d       = hc_lo_q;
        idx_d         = idx_q;
        raise_err     = 1'b0;
        new_code      = ErrNone;
        ram_we        = 1'b0;
        ram_waddr     = '0;
        ram_wdata     = din;

        unique case (state_q)
            StNone: begin
                if (wr_en) begin
                    if (din != 8'h00) begin
                        raise_err = 1'b1;
                        new_code  = ErrBadStart;
                    end else begin
                        new_d   = 1'b1;
                        full_d  = 1'b1;
                        state_d = StWaitApplied;
                    end
                end
            end
            StWaitApplied: begin
                // Any byte offered here is dropped; upstream must honour full.
                if (cmp_config_applied) begin
                    new_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = StSaltLen;
                end
            end
            StSaltLen: begin
                if (wr_en) begin
                    if (32'(din) < SALT_MIN || 32'(din) > SALT_MAX) begin
                        raise_err = 1'b1;
                        new_code  = ErrSaltLen;
                    end else begin
                        salt_len_d = din;
                        idx_d      = 8'd0;
                        ram_we     = 1'b1;
                        ram_waddr  = AW'(SaltLenAddr);
                        state_d    = StSalt;
                    end
                end
            end
            StSalt: begin
                if (wr_en) begin
                    ram_we    = 1'b1;
                    ram_waddr = AW'(SaltBase + 32'(idx_q));
                    ram_wdata = (idx_q < salt_len_q) ? din : 8'h00;
                    if (idx_q == 8'(SALT_MAX - 1)) begin
                        idx_d   = 8'd0;
                        state_d = StIter;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            StIter: begin
                if (wr_en) begin
                    ram_we       = 1'b1;
                    ram_waddr    = AW'(IterBase + 32'(idx_q));
                    iter_count_d = iter_shift;
                    if (idx_q == 8'(ITER_BYTES - 1)) begin
                        idx_d = 8'd0;
                        if (iter_shift == '0) begin
                            raise_err = 1'b1;
                            new_code  = ErrZeroIter;
                        end else begin
                            state_d = StHc0;
                        end
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            StHc0: begin
                if (wr_en) begin
                    if (!mode_cmp && din != 8'h00) begin
                        raise_err = 1'b1;
                        new_code  = ErrUnexpectedCmp;
                    end else begin
                        hc_lo_d = din;
                        state_d = StHc1;
                    end
                end
            end
            StHc1: begin
                if (wr_en) begin
                    if (!mode_cmp && din != 8'h00) begin
                        raise_err = 1'b1;
                        new_code  = ErrUnexpectedCmp;
                    end else if (mode_cmp && (hc_full == 16'd0 || 32'(hc_full) > NUM_HASHES)) begin
                        raise_err = 1'b1;
                        new_code  = ErrHashCount;
                    end else begin
                        hash_count_d  = HC_W'(hc_full);
                        // Preset so the first comparator byte increments to address 0.
                        cmp_wr_addr_d = '1;
                        state_d       = mode_cmp ? StCmpData : StMagic;
                    end
                end
            end
            StCmpData: begin
                if (wr_en) begin
                    cmp_wr_en_d   = 1'b1;
                    cmp_din_d     = din;
                    cmp_wr_addr_d = cmp_wr_addr_q + CA_W'(1);
                    if (cmp_wr_addr_d == cmp_last) begin
                        state_d = StMagic;
                    end
                end
            end
            StMagic: begin
                if (wr_en) begin
                    if (din == 8'hCC) begin
                        done_d  = 1'b1;
                        state_d = StNone;
                    end else begin
                        raise_err = 1'b1;
                        new_code  = ErrBadMagic;
                    end
                end
            end
            StError: begin
            end
            default: state_d = StNone;
        endcase

        if (raise_err) begin
            state_d    = StError;
            error_d    = 1'b1;
            err_code_d = new_code;
            full_d     = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StNone;
            full_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ErrNone;
            new_q         <= 1'b0;
            done_q        <= 1'b0;
            cmp_wr_en_q   <= 1'b0;
            cmp_wr_addr_q <= '1;
            cmp_din_q     <= 8'h00;
            hash_count_q  <= '0;
            iter_count_q  <= '0;
            salt_len_q    <= 8'h00;
            hc_lo_q       <= 8'h00;
            idx_q         <= 8'h00;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            new_q         <= new_d;
            done_q        <= done_d;
            cmp_wr_en_q   <= cmp_wr_en_d;
            cmp_wr_addr_q <= cmp_wr_addr_d;
            cmp_din_q     <= cmp_din_d;
            hash_count_q  <= hash_count_d;
            iter_count_q  <= iter_count_d;
            salt_len_q    <= salt_len_d;
            hc_lo_q       <= hc_lo_d;
            idx_q         <= idx_d;
        end
    end

    cmp_config_ram #(
        .AW(AW)
    ) u_ram (
        .CLK  (CLK),
        .we   (ram_we & ~RST),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(addr),
        .rdata(ram_rdata)
    );

    // Addresses outside the defined fields always read zero.
    assign rd_valid = (32'(addr) < IterBase + ITER_BYTES) || (32'(addr) == SaltLenAddr) ||
                      (32'(addr) >= SaltBase && 32'(addr) < SaltBase + SALT_MAX);
    assign dout     = rd_valid ? ram_rdata : 8'h00;

    assign full           = full_q;
    assign error          = error_q;
    assign err_code       = err_code_q;
    assign new_cmp_config = new_q;
    assign done           = done_q;
    assign cmp_wr_en      = cmp_wr_en_q;
    assign cmp_wr_addr    = cmp_wr_addr_q;
    assign cmp_din        = cmp_din_q;
    assign hash_count     = hash_count_q;
    assign iter_count     = iter_count_q;

endmodule

// File: tb/tb_cmp_config_param.sv
// Directed bench for cmp_config_param with default parameters
// (SALT_MAX=16, ITER_BYTES=4, CMP_BYTES=4, NUM_HASHES=512).
module tb_cmp_config_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mode_cmp;
    logic [7:0]  din;
    logic        wr_en;
    logic        full;
    logic        error;
    logic [2:0]  err_code;
    logic        new_cmp_config;
    logic        cmp_config_applied;
    logic        done;
    logic [9:0]  hash_count;
    logic [10:0] cmp_wr_addr;
    logic        cmp_wr_en;
    logic [7:0]  cmp_din;
    logic [31:0] iter_count;
    logic [4:0]  addr;
    logic [7:0]  dout;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cmp_config_param dut (
        .CLK               (CLK),
        .RST               (RST),
        .mode_cmp          (mode_cmp),
        .din               (din),
        .wr_en             (wr_en),
        .full              (full),
        .error             (error),
        .err_code          (err_code),
        .new_cmp_config    (new_cmp_config),
        .cmp_config_applied(cmp_config_applied),
        .done              (done),
        .hash_count        (hash_count),
        .cmp_wr_addr       (cmp_wr_addr),
        .cmp_wr_en         (cmp_wr_en),
        .cmp_din           (cmp_din),
        .iter_count        (iter_count),
        .addr              (addr),
        .dout              (dout)
    );

    task automatic push(input logic [7:0] b);
        @(negedge CLK);
        din   = b;
        wr_en = 1'b1;
        @(posedge CLK);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST                = 1'b1;
        wr_en              = 1'b0;
        cmp_config_applied = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic start_packet();
        push(8'h00);
        @(negedge CLK);
        cmp_config_applied = 1'b1;
        @(posedge CLK);
        #1;
        cmp_config_applied = 1'b0;
    endtask

    task automatic send_to_hc(input logic [7:0] slen, input logic [7:0] sb,
                              input logic [31:0] iter);
        push(slen);
        for (int i = 0; i < 16; i++) push(sb + 8'(i));
        for (int i = 0; i < 4; i++) push(iter[8*i +: 8]);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({full, error, err_code, new_cmp_config, done, cmp_wr_en} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {full, error, err_code, new_cmp_config, done, cmp_wr_en});
        end
        checks++;
        if (cmp_wr_addr !== 11'h7FF) begin
            errors++;
            $display("FAIL reset_cmp_wr_addr: got %h want 7ff", cmp_wr_addr);
        end
        checks++;
        if ({hash_count, iter_count, cmp_din} !== 50'd0) begin
            errors++;
            $display("FAIL reset_data: got hc=%h iter=%h cmp_din=%h want 0",
                     hash_count, iter_count, cmp_din);
        end
    endtask

    task automatic test_cmp_packet();
        do_reset();
        mode_cmp = 1'b1;
        start_packet();
        send_to_hc(8'd5, 8'h11, 32'd5000);
        push(8'h02);
        push(8'h00);
        checks++;
        if (hash_count !== 10'd2 || cmp_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL cmp_hash_count: got hc=%0d en=%b want 2/0", hash_count, cmp_wr_en);
        end
        for (int i = 0; i < 8; i++) begin
            push(8'hA0 + 8'(i));
            checks++;
            if ({cmp_wr_en, cmp_wr_addr, cmp_din} !== {1'b1, 11'(i), 8'hA0 + 8'(i)}) begin
                errors++;
                $display("FAIL cmp_byte%0d: got en=%b a=%0d d=%h want en=1 a=%0d d=%h", i,
                         cmp_wr_en, cmp_wr_addr, cmp_din, i, 8'hA0 + 8'(i));
            end
        end
        push(8'hCC);
        checks++;
        if ({done, cmp_wr_en, error} !== 3'b100 || iter_count !== 32'd5000) begin
            errors++;
            $display("FAIL cmp_magic: got done=%b en=%b err=%b iter=%0d want 1/0/0/5000",
                     done, cmp_wr_en, error, iter_count);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL cmp_done_pulse: got %b want 0", done);
        end
        addr = 5'd4;
        #1;
        checks++;
        if (dout !== 8'd5) begin
            errors++;
            $display("FAIL cmp_ram_salt_len: got %h want 05", dout);
        end
        for (int i = 8; i < 24; i++) begin
            addr = 5'(i);
            #1;
            checks++;
            if (dout !== ((i < 13) ? 8'h11 + 8'(i - 8) : 8'h00)) begin
                errors++;
                $display("FAIL cmp_ram_salt%0d: got %h want %h", i, dout,
                         (i < 13) ? 8'h11 + 8'(i - 8) : 8'h00);
            end
        end
        addr = 5'd0;
        #1;
        checks++;
        if (dout !== 8'h88) begin
            errors++;
            $display("FAIL cmp_ram_iter0: got %h want 88", dout);
        end
        addr = 5'd1;
        #1;
        checks++;
        if (dout !== 8'h13) begin
            errors++;
            $display("FAIL cmp_ram_iter1: got %h want 13", dout);
        end
    endtask

    task automatic test_no_cmp();
        do_reset();
        mode_cmp = 1'b0;
        start_packet();
        send_to_hc(8'd1, 8'h55, 32'd1);
        push(8'h00);
        push(8'h00);
        checks++;
        if ({cmp_wr_en, error} !== 2'b00 || hash_count !== 10'd0) begin
            errors++;
            $display("FAIL nocmp_hc: got en=%b err=%b hc=%0d want 0/0/0", cmp_wr_en, error,
                     hash_count);
        end
        push(8'hCC);
        checks++;
        if ({done, cmp_wr_en, error} !== 3'b100 || iter_count !== 32'd1) begin
            errors++;
            $display("FAIL nocmp_done: got done=%b en=%b err=%b iter=%0d want 1/0/0/1",
                     done, cmp_wr_en, error, iter_count);
        end
        addr = 5'd9;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL nocmp_salt_pad: got %h want 00", dout);
        end
        start_packet();
        send_to_hc(8'd1, 8'h55, 32'd1);
        push(8'h01);
        checks++;
        if ({error, err_code, full} !== {1'b1, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL unexpected_cmp: got err=%b code=%0d full=%b want 1/5/1",
                     error, err_code, full);
        end
    endtask

    task automatic test_salt_len_err();
        logic [7:0] bad [2];
        bad[0] = 8'd0;
        bad[1] = 8'd17;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            mode_cmp = 1'b0;
            start_packet();
            push(bad[k]);
            checks++;
            if ({error, err_code} !== {1'b1, 3'd2}) begin
                errors++;
                $display("FAIL salt_len_%0d: got err=%b code=%0d want 1/2", bad[k], error,
                         err_code);
            end
            for (int i = 0; i < 20; i++) push(8'h00);
            push(8'hCC);
            checks++;
            if ({error, err_code, full, done, cmp_wr_en} !== {1'b1, 3'd2, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL salt_len_sticky_%0d: got err=%b code=%0d full=%b done=%b en=%b",
                         bad[k], error, err_code, full, done, cmp_wr_en);
            end
        end
        do_reset();
        push(8'h5A);
        checks++;
        if ({error, err_code, new_cmp_config} !== {1'b1, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL bad_start: got err=%b code=%0d new=%b want 1/1/0", error, err_code,
                     new_cmp_config);
        end
    endtask

    task automatic test_range_errors();
        do_reset();
        mode_cmp = 1'b1;
        start_packet();
        send_to_hc(8'd4, 8'h20, 32'd0);
        checks++;
        if ({error, err_code} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL zero_iter: got err=%b code=%0d want 1/3", error, err_code);
        end
        do_reset();
        start_packet();
        send_to_hc(8'd4, 8'h20, 32'd7);
        push(8'h01);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL hc_over_early: got err=%b want 0", error);
        end
        push(8'h02);
        checks++;
        if ({error, err_code} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL hc_over: got err=%b code=%0d want 1/4", error, err_code);
        end
        do_reset();
        start_packet();
        send_to_hc(8'd4, 8'h20, 32'd7);
        push(8'h00);
        push(8'h00);
        checks++;
        if ({error, err_code} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL hc_zero_cmp: got err=%b code=%0d want 1/4", error, err_code);
        end
        do_reset();
        mode_cmp = 1'b0;
        start_packet();
        send_to_hc(8'd4, 8'h20, 32'd7);
        push(8'h00);
        push(8'h00);
        push(8'hCD);
        checks++;
        if ({error, err_code, done} !== {1'b1, 3'd6, 1'b0}) begin
            errors++;
            $display("FAIL bad_magic: got err=%b code=%0d done=%b want 1/6/0", error, err_code,
                     done);
        end
    endtask

    task automatic test_applied_delay();
        do_reset();
        mode_cmp = 1'b0;
        push(8'h00);
        checks++;
        if ({full, new_cmp_config} !== 2'b11) begin
            errors++;
            $display("FAIL full_rise: got full=%b new=%b want 1/1", full, new_cmp_config);
        end
        @(negedge CLK);
        din   = 8'h07;
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if ({full, new_cmp_config} !== 2'b11) begin
                errors++;
                $display("FAIL full_hold%0d: got full=%b new=%b want 1/1", i, full,
                         new_cmp_config);
            end
        end
        @(negedge CLK);
        cmp_config_applied = 1'b1;
        @(posedge CLK);
        #1;
        cmp_config_applied = 1'b0;
        wr_en              = 1'b0;
        checks++;
        if ({full, new_cmp_config} !== 2'b00) begin
            errors++;
            $display("FAIL full_release: got full=%b new=%b want 0/0", full, new_cmp_config);
        end
        send_to_hc(8'd7, 8'h40, 32'd3);
        push(8'h00);
        push(8'h00);
        push(8'hCC);
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("FAIL release_drop: got done=%b err=%b code=%0d want 1/0", done, error,
                     err_code);
        end
        addr = 5'd15;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL release_salt_pad: got %h want 00", dout);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mode_cmp = 1'b1;
        start_packet();
        send_to_hc(8'd2, 8'h60, 32'd9);
        push(8'h02);
        push(8'h00);
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if ({full, error, err_code, new_cmp_config, done, cmp_wr_en} !== 8'h00 ||
            cmp_wr_addr !== 11'h7FF || {hash_count, iter_count, cmp_din} !== 50'd0) begin
            errors++;
            $display("FAIL mid_reset: got en=%b a=%h hc=%0d iter=%0d d=%h", cmp_wr_en,
                     cmp_wr_addr, hash_count, iter_count, cmp_din);
        end
        @(negedge CLK);
        RST = 1'b0;
        start_packet();
        send_to_hc(8'd3, 8'h70, 32'h01020304);
        push(8'h01);
        push(8'h00);
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        checks++;
        if ({cmp_wr_en, cmp_wr_addr, cmp_din} !== {1'b1, 11'd3, 8'hB3}) begin
            errors++;
            $display("FAIL fresh_last_cmp: got en=%b a=%0d d=%h want 1/3/b3", cmp_wr_en,
                     cmp_wr_addr, cmp_din);
        end
        push(8'hCC);
        checks++;
        if ({done, error} !== 2'b10 || hash_count !== 10'd1 || iter_count !== 32'h01020304) begin
            errors++;
            $display("FAIL fresh_done: got done=%b err=%b hc=%0d iter=%h", done, error,
                     hash_count, iter_count);
        end
        push(8'h00);
        checks++;
        if ({done, full, new_cmp_config, error} !== 4'b0110) begin
            errors++;
            $display("FAIL back_to_back: got done=%b full=%b new=%b err=%b want 0/1/1/0",
                     done, full, new_cmp_config, error);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST                = 1'b1;
        mode_cmp           = 1'b0;
        din                = 8'h00;
        wr_en              = 1'b0;
        cmp_config_applied = 1'b0;
        addr               = 5'd0;
        test_reset();
        test_cmp_packet();
        test_no_cmp();
        test_salt_len_err();
        test_range_errors();
        test_applied_delay();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
